// File: rtl/rs2_read_arbiter.sv
// rs2_read_arbiter: round-robin arbiter sharing register-file read port 2 among add, mult and muladd controllers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module rs2_read_arbiter #(
    parameter logic [1:0] ADD    = 2'b00,
    parameter logic [1:0] MULT   = 2'b01,
    parameter logic [1:0] MULADD = 2'b10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_add,
    input  logic                        req_mult,
    input  logic                        req_muladd,
    input  logic [`DATA_WIDTH-1:0]      rs2_rdata,
    output logic [1:0]                  rs2_sel,
    output logic                        gnt_add,
    output logic                        gnt_mult,
    output logic                        gnt_muladd,
    output logic                        vld_add,
    output logic                        vld_mult,
    output logic                        vld_muladd,
    output logic [`DATA_WIDTH-1:0]      rs2_dout
);
    localparam int DATA_WIDTH = `DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
    state_t                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d, sel_q, sel_d, c1, c2, win;
    logic [2:0]            req, elig, gnt_q, gnt_d, vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  go;
    function automatic logic [1:0] code(input logic [1:0] i);
        return i == 2'd0 ? ADD : i == 2'd1 ? MULT : MULADD;
    endfunction
    // ptr_q is the last winner, which is also the owner of the transaction in GRANT/RESP
    always_comb begin
        req     = {req_muladd, req_mult, req_add};
        elig    = state_q == RESP ? req & ~(3'b001 << ptr_q) : req;
        c1      = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
        c2      = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
        win     = elig[c1] ? c1 : elig[c2] ? c2 : ptr_q;
        go      = |elig && state_q != GRANT;
        state_d = state_q == GRANT ? RESP : go ? GRANT : IDLE;
        ptr_d   = go ? win : ptr_q;
        sel_d   = go ? code(win) : sel_q;
        gnt_d   = go ? 3'b001 << win : 3'b000;
        vld_d   = state_q == RESP ? 3'b001 << ptr_q : 3'b000;
        dout_d  = state_q == RESP ? rs2_rdata : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            sel_q   <= ADD;
            gnt_q   <= 3'b000;
            vld_q   <= 3'b000;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end
    assign rs2_sel                          = sel_q;
    assign {gnt_muladd, gnt_mult, gnt_add}  = gnt_q;
    assign {vld_muladd, vld_mult, vld_add}  = vld_q;
    assign rs2_dout                         = dout_q;
endmodule

// File: tb/tb_rs2_read_arbiter.sv
// tb_rs2_read_arbiter: directed and random-traffic checks of rs2_read_arbiter grants, latency and data return.
module tb_rs2_read_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_add = 1'b0, req_mult = 1'b0, req_muladd = 1'b0;
    logic [31:0] rs2_rdata = '0, rs2_dout, rd_cur;
    logic [1:0]  rs2_sel;
    logic        gnt_add, gnt_mult, gnt_muladd, vld_add, vld_mult, vld_muladd;
    logic [2:0]  gnt, vld;
    int          n_chk = 0, n_pass = 0;
    int          waits[3];
    bit          pend[3], got[3];

    rs2_read_arbiter dut (
        .clk(clk), .rst(rst),
        .req_add(req_add), .req_mult(req_mult), .req_muladd(req_muladd),
        .rs2_rdata(rs2_rdata), .rs2_sel(rs2_sel),
        .gnt_add(gnt_add), .gnt_mult(gnt_mult), .gnt_muladd(gnt_muladd),
        .vld_add(vld_add), .vld_mult(vld_mult), .vld_muladd(vld_muladd),
        .rs2_dout(rs2_dout)
    );

    always #5 clk = ~clk;
    assign gnt = {gnt_muladd, gnt_mult, gnt_add};
    assign vld = {vld_muladd, vld_mult, vld_add};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [2:0] g, input logic [2:0] v, input logic [1:0] s);
        check({tag, "_gnt"}, 64'(gnt), 64'(g));
        check({tag, "_vld"}, 64'(vld), 64'(v));
        check({tag, "_sel"}, 64'(rs2_sel), 64'(s));
    endtask

    initial begin
        // reset with a request pending: reset must win
        req_add = 1'b1;
        step();
        step();
        expect_o("rst", 3'b000, 3'b000, 2'b00);
        check("rst_dout", 64'(rs2_dout), 64'h0);
        req_add = 1'b0;
        rst = 1'b0;
        step();
        expect_o("idle", 3'b000, 3'b000, 2'b00);

        // single mult read
        req_mult = 1'b1;
        rs2_rdata = 32'hDEAD_BEEF;
        step();
        expect_o("mult_g", 3'b010, 3'b000, 2'b01);
        step();
        expect_o("mult_r", 3'b000, 3'b000, 2'b01);
        step();
        expect_o("mult_v", 3'b000, 3'b010, 2'b01);
        check("mult_dout", 64'(rs2_dout), 64'hDEAD_BEEF);
        req_mult = 1'b0;
        rs2_rdata = 32'h1111_2222;
        step();
        expect_o("mult_done", 3'b000, 3'b000, 2'b01);
        check("dout_hold", 64'(rs2_dout), 64'hDEAD_BEEF);

        // round robin with all three held, starting from reset priority
        rst = 1'b1;
        step();
        rst = 1'b0;
        {req_muladd, req_mult, req_add} = 3'b111;
        step();
        expect_o("rr0", 3'b001, 3'b000, 2'b00);
        step();
        expect_o("rr0r", 3'b000, 3'b000, 2'b00);
        step();
        expect_o("rr1", 3'b010, 3'b001, 2'b01);
        step();
        step();
        expect_o("rr2", 3'b100, 3'b010, 2'b10);
        step();
        step();
        expect_o("rr3", 3'b001, 3'b100, 2'b00);
        {req_muladd, req_mult, req_add} = 3'b000;
        step();
        step();
        expect_o("rr_end", 3'b000, 3'b001, 2'b00);
        step();
        expect_o("rr_idle", 3'b000, 3'b000, 2'b00);

        // lone add: one transaction only, then idle
        req_add = 1'b1;
        rs2_rdata = 32'h1234_5678;
        step();
        expect_o("add_g", 3'b001, 3'b000, 2'b00);
        step();
        step();
        expect_o("add_v", 3'b000, 3'b001, 2'b00);
        check("add_dout", 64'(rs2_dout), 64'h1234_5678);
        req_add = 1'b0;
        step();
        expect_o("add_idle", 3'b000, 3'b000, 2'b00);
        step();
        expect_o("add_idle2", 3'b000, 3'b000, 2'b00);

        // reset during RESP of a mult grant abandons it
        req_mult = 1'b1;
        rs2_rdata = 32'hAAAA_5555;
        step();
        expect_o("ab_g", 3'b010, 3'b000, 2'b01);
        step();
        rst = 1'b1;
        step();
        expect_o("ab_rst", 3'b000, 3'b000, 2'b00);
        check("ab_dout", 64'(rs2_dout), 64'h0);
        rst = 1'b0;
        step();
        expect_o("ab_regnt", 3'b010, 3'b000, 2'b01);
        step();
        step();
        expect_o("ab_v", 3'b000, 3'b010, 2'b01);
        check("ab_vdout", 64'(rs2_dout), 64'hAAAA_5555);
        req_mult = 1'b0;
        step();

        // muladd arriving during ADD RESP is granted right after RESP
        req_add = 1'b1;
        rs2_rdata = 32'h0BAD_F00D;
        step();
        expect_o("ov_g", 3'b001, 3'b000, 2'b00);
        step();
        req_muladd = 1'b1;
        step();
        expect_o("ov_gm", 3'b100, 3'b001, 2'b10);
        check("ov_dout", 64'(rs2_dout), 64'h0BAD_F00D);
        req_add = 1'b0;
        rs2_rdata = 32'h5A5A_0001;
        step();
        step();
        expect_o("ov_vm", 3'b000, 3'b100, 2'b10);
        check("ov_mdout", 64'(rs2_dout), 64'h5A5A_0001);
        req_muladd = 1'b0;
        step();
        expect_o("ov_idle", 3'b000, 3'b000, 2'b10);

        // random traffic; requesters hold until their vld
        rd_cur = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            check("gnt_1hot", 64'($onehot0(gnt)), 64'd1);
            check("vld_1hot", 64'($onehot0(vld)), 64'd1);
            check("sel_ne3", 64'(rs2_sel != 2'b11), 64'd1);
            if (vld != 3'b000) check("rnd_dout", 64'(rs2_dout), 64'(rd_cur));
            for (int r = 0; r < 3; r++) if (gnt[r]) begin
                check("rnd_sel", 64'(rs2_sel), 64'(r));
                check("rnd_pend", 64'(pend[r]), 64'd1);
                for (int k = 0; k < 3; k++) if (k != r && pend[k] && !got[k]) begin
                    waits[k]++;
                    check("rr_wait", 64'(waits[k] <= 2), 64'd1);
                end
                got[r] = 1'b1;
                waits[r] = 0;
            end
            for (int r = 0; r < 3; r++) begin
                if (vld[r]) begin
                    pend[r] = 1'b0;
                    got[r] = 1'b0;
                end else if (!pend[r] && c < 360 && $urandom_range(0, 2) == 0) pend[r] = 1'b1;
            end
            {req_muladd, req_mult, req_add} = {pend[2], pend[1], pend[0]};
            rd_cur = $urandom;
            rs2_rdata = rd_cur;
        end
        check("rnd_drain", 64'({pend[2], pend[1], pend[0]}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs2_read_arbiter.md
RS2_READ_ARBITER -- requirements
Module: rs2_read_arbiter

Interface
REQ-001 The module SHALL have parameter ADD, default 2'b00, the rs2_sel code for the add controller.
REQ-002 The module SHALL have parameter MULT, default 2'b01, the rs2_sel code for the mult controller.
REQ-003 The module SHALL have parameter MULADD, default 2'b10, the rs2_sel code for the muladd controller.
REQ-004 The module SHALL have local parameter DATA_WIDTH, taken from `DATA_WIDTH in defines.vh, the register width.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset, with port clk (input, 1 bit, rising-edge clock).
REQ-006 The module SHALL have port rst (input, 1 bit), the synchronous active-high reset.
REQ-007 The module SHALL have port req_add (input, 1 bit), the add controller's rs2 read request (level).
REQ-008 The module SHALL have port req_mult (input, 1 bit), the mult controller's rs2 read request (level).
REQ-009 The module SHALL have port req_muladd (input, 1 bit), the muladd controller's rs2 read request (level).
REQ-010 The module SHALL have port rs2_rdata (input, DATA_WIDTH bits), the register-file port-2 read data, valid one cycle after the address.
REQ-011 The module SHALL have port rs2_sel (output, 2 bits), the select driving the rs2 address mux.
REQ-012 The module SHALL have ports gnt_add, gnt_mult and gnt_muladd (output, 1 bit each), the one-hot grants, high in the GRANT state only.
REQ-013 The module SHALL have ports vld_add, vld_mult and vld_muladd (output, 1 bit each), one-cycle pulses marking data valid for that controller.
REQ-014 The module SHALL have port rs2_dout (output, DATA_WIDTH bits), the registered read data returned to the controllers.

Function
REQ-015 The module SHALL implement an FSM with states IDLE, GRANT and RESP, with every output registered.
REQ-016 In IDLE, on any request high, the FSM SHALL move to GRANT next cycle, latching the winner into rs2_sel and asserting the matching gnt_*.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE and rs2_sel SHALL hold its last value.
REQ-018 GRANT SHALL last exactly one cycle, with the FSM then moving to RESP; rs2_sel SHALL stay stable through GRANT and RESP.
REQ-019 In RESP, rs2_rdata SHALL be captured into rs2_dout at the clock edge ending RESP, and the winner's vld_* SHALL pulse high for exactly the next cycle.
REQ-020 Latency SHALL be: request sampled at edge E, gnt at E+1, rs2_dout and vld_* at E+3.
REQ-021 Arbitration SHALL be round-robin: a 2-bit last-winner pointer, with priority order starting at the controller after the last winner (ADD->MULT->MULADD->ADD).
REQ-022 The pointer SHALL update only when a grant is issued.
REQ-023 From RESP, the FSM SHALL go directly to GRANT if any request other than the current winner's is high, and otherwise to IDLE.
REQ-024 The current winner's request SHALL be masked during that RESP decision, so one transaction cannot be served twice.
REQ-025 Back-to-back operation SHALL give 1 grant per 2 cycles, and a vld_* pulse SHALL be able to coincide with the next gnt_*.
REQ-026 Requesters SHALL hold req_* high until their vld_*; a request dropped before its grant SHALL simply not be granted.
REQ-027 A request dropped after its grant SHALL not abort the transaction: vld_* still pulses.
REQ-028 rs2_sel SHALL never be driven to 2'b11.
REQ-029 At most one gnt_* SHALL be high at a time, and at most one vld_* SHALL be high at a time.
REQ-030 rs2_dout SHALL hold its value between vld_* pulses.

Reset
REQ-031 When rst is high at a rising edge, the FSM SHALL go to IDLE, rs2_sel SHALL be ADD, all gnt_* and vld_* SHALL be 0, rs2_dout SHALL be 0, and the pointer SHALL be MULADD, so that ADD has highest priority.
REQ-032 Reset asserted in GRANT or RESP SHALL abandon the transaction: no vld_* pulse follows, and requests are re-arbitrated after rst falls.
REQ-033 Reset SHALL override all requests in the same cycle.

Verification
REQ-034 Reset followed by req_mult alone, with rs2_rdata=32'hDEAD_BEEF in RESP, SHALL give gnt_mult at E+1, rs2_sel=01, and vld_mult with rs2_dout=32'hDEAD_BEEF at E+3.
REQ-035 All three requests held high after reset SHALL be granted in the order ADD, MULT, MULADD, ADD, with grants 2 cycles apart and rs2_sel sequence 00,01,10,00.
REQ-036 req_add alone, held through its vld_add, SHALL produce exactly one transaction with no re-grant from RESP, and the FSM SHALL return to IDLE.
REQ-037 rst pulsed during RESP of a mult grant SHALL give no vld_mult, and all outputs SHALL be at reset values the next cycle.
REQ-038 req_muladd arriving during an ADD RESP SHALL cause a GRANT of MULADD in the cycle immediately after RESP, with vld_add coinciding with gnt_muladd.
REQ-039 Random request traffic SHALL keep gnt_* one-hot, keep rs2_sel != 11, and give every held request a grant within 3 grants.
